// File: rtl/cart_rom_loader.sv
// cart_rom_loader
//   Captures a cartridge image streamed over the HPS ioctl download port
//   (selected by ioctl_index == INDEX). It packs the bytes into 16-bit
//   big-endian words (even byte in [15:8], odd byte in [7:0]) and writes
//   them into the cartridge ROM RAM. The CPU is held in reset while the
//   download is in progress. The loader also reports the image size and
//   an address mirror mask.
//
// Ports
//   clk_sys         system clock, all logic on the rising edge
//   reset           synchronous active-high reset
//   ioctl_download  download in progress
//   ioctl_index     download target index
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address of ioctl_data
//   ioctl_data      download byte
//   ioctl_wait      back-pressure to HPS while a ROM write is outstanding
//   rom_addr        ROM word address
//   rom_din         ROM word data
//   rom_we          ROM write request, held until rom_ack
//   rom_ack         one-cycle ROM write acknowledge
//   cart_size       bytes loaded, saturating at 2^ADDR_W
//   cart_mask       next power of two >= cart_size (min 256), minus 1
//   cart_valid      image present and complete
//   cpu_hold        CPU reset request
//   load_err        sticky: a byte arrived while ioctl_wait was high
module cart_rom_loader #(
    parameter int         ADDR_W = 15,
    parameter logic [7:0] INDEX  = 8'd1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    output logic              ioctl_wait,
    output logic [ADDR_W-2:0] rom_addr,
    output logic [15:0]       rom_din,
    output logic              rom_we,
    input  logic              rom_ack,
    output logic [ADDR_W:0]   cart_size,
    output logic [ADDR_W-1:0] cart_mask,
    output logic              cart_valid,
    output logic              cpu_hold,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic              dl_q;
    logic              pending, pending_n;
    logic [ADDR_W-2:0] pend_word, pend_word_n;
    logic [7:0]        pend_hi, pend_hi_n;
    logic              stash, stash_n;
    logic [ADDR_W-2:0] stash_word, stash_word_n;
    logic              stash_odd, stash_odd_n;
    logic [7:0]        stash_data, stash_data_n;
    logic              end_seen, end_seen_n;

    logic              wait_n;
    logic [ADDR_W-2:0] rom_addr_n;
    logic [15:0]       rom_din_n;
    logic              rom_we_n;
    logic [ADDR_W:0]   cart_size_n;
    logic [ADDR_W-1:0] cart_mask_n;
    logic              cart_valid_n;
    logic              cpu_hold_n;
    logic              load_err_n;

    logic              index_hit;
    logic              dl_rise;
    logic              dl_fall;
    logic              byte_strobe;
    logic              in_range;
    logic              byte_odd;
    logic [ADDR_W-2:0] byte_word;
    logic [ADDR_W:0]   size_cand;
    logic [ADDR_W-1:0] smear;
    logic [ADDR_W-1:0] mask_calc;

    assign index_hit   = (ioctl_index == INDEX);
    assign dl_rise     = ioctl_download & ~dl_q & index_hit;
    assign dl_fall     = ~ioctl_download & dl_q;
    assign byte_strobe = ioctl_wr & index_hit;
    assign in_range    = (ioctl_addr[24:ADDR_W] == '0);
    assign byte_odd    = ioctl_addr[0];
    assign byte_word   = ioctl_addr[ADDR_W-1:1];
    assign size_cand   = in_range ? ({1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1))
                                  : {1'b1, {ADDR_W{1'b0}}};

    // Mirror mask: smear the highest set bit of (size-1) downwards, with a
    // 256-byte floor. size 2^ADDR_W wraps the low bits to zero so size-1 is
    // all ones, which is the wanted full mask.
    always_comb begin
        smear = cart_size[ADDR_W-1:0] - ADDR_W'(1);
        for (int unsigned i = 1; i < ADDR_W; i++) begin
            smear[ADDR_W-1-i] = smear[ADDR_W-1-i] | smear[ADDR_W-i];
        end
        mask_calc = (cart_size == '0) ? '0 : (smear | ADDR_W'(8'hFF));
    end

    always_comb begin
        state_n      = state;
        pending_n    = pending;
        pend_word_n  = pend_word;
        pend_hi_n    = pend_hi;
        stash_n      = stash;
        stash_word_n = stash_word;
        stash_odd_n  = stash_odd;
        stash_data_n = stash_data;
        end_seen_n   = end_seen;
        wait_n       = ioctl_wait;
        rom_addr_n   = rom_addr;
        rom_din_n    = rom_din;
        rom_we_n     = rom_we;
        cart_size_n  = cart_size;
        cart_mask_n  = cart_mask;
        cart_valid_n = cart_valid;
        cpu_hold_n   = cpu_hold;
        load_err_n   = load_err;

        if (byte_strobe && ioctl_wait) begin
            load_err_n = 1'b1;
        end

        case (state)
            S_IDLE: begin
                cpu_hold_n = 1'b0;
                if (dl_rise) begin
                    state_n      = S_COLLECT;
                    cpu_hold_n   = 1'b1;
                    cart_valid_n = 1'b0;
                    cart_size_n  = '0;
                    pending_n    = 1'b0;
                    stash_n      = 1'b0;
                    end_seen_n   = 1'b0;
                    load_err_n   = 1'b0;
                end
            end

            S_COLLECT: begin
                if (byte_strobe) begin
                    if (size_cand > cart_size) begin
                        cart_size_n = size_cand;
                    end
                    if (in_range) begin
                        if (pending && (byte_word != pend_word)) begin
                            // Flush the orphaned even byte first; the new byte
                            // waits in the stash until that write is acked.
                            rom_addr_n   = pend_word;
                            rom_din_n    = {pend_hi, 8'hFF};
                            rom_we_n     = 1'b1;
                            wait_n       = 1'b1;
                            stash_n      = 1'b1;
                            stash_word_n = byte_word;
                            stash_odd_n  = byte_odd;
                            stash_data_n = ioctl_data;
                            state_n      = S_WRITE;
                        end else if (byte_odd) begin
                            rom_addr_n = byte_word;
                            rom_din_n  = {(pending ? pend_hi : 8'hFF), ioctl_data};
                            rom_we_n   = 1'b1;
                            wait_n     = 1'b1;
                            state_n    = S_WRITE;
                        end else begin
                            pending_n   = 1'b1;
                            pend_word_n = byte_word;
                            pend_hi_n   = ioctl_data;
                        end
                    end
                end
                // A final byte on the same cycle as the falling edge is
                // handled above first; its write then leads into FLUSH.
                if (dl_fall) begin
                    end_seen_n = 1'b1;
                    if (state_n == S_COLLECT) begin
                        state_n = S_FLUSH;
                    end
                end
            end

            S_WRITE: begin
                if (dl_fall) begin
                    end_seen_n = 1'b1;
                end
                if (rom_ack) begin
                    pending_n = 1'b0;
                    if (stash && stash_odd) begin
                        // Lone odd byte from the stash: issue it back-to-back.
                        stash_n    = 1'b0;
                        rom_addr_n = stash_word;
                        rom_din_n  = {8'hFF, stash_data};
                    end else begin
                        if (stash) begin
                            stash_n     = 1'b0;
                            pending_n   = 1'b1;
                            pend_word_n = stash_word;
                            pend_hi_n   = stash_data;
                        end
                        rom_we_n = 1'b0;
                        wait_n   = 1'b0;
                        state_n  = (end_seen || dl_fall) ? S_FLUSH : S_COLLECT;
                    end
                end
            end

            S_FLUSH: begin
                if (pending) begin
                    rom_addr_n = pend_word;
                    rom_din_n  = {pend_hi, 8'hFF};
                    rom_we_n   = 1'b1;
                    wait_n     = 1'b1;
                    state_n    = S_WRITE;
                end else begin
                    state_n = S_DONE;
                end
            end

            S_DONE: begin
                cart_mask_n  = mask_calc;
                cart_valid_n = (cart_size != '0);
                state_n      = S_IDLE;
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Treat the download line as already high so that a download
            // still in progress across reset is not picked up half-way.
            dl_q       <= 1'b1;
            pending    <= 1'b0;
            pend_word  <= '0;
            pend_hi    <= '0;
            stash      <= 1'b0;
            stash_word <= '0;
            stash_odd  <= 1'b0;
            stash_data <= '0;
            end_seen   <= 1'b0;
            ioctl_wait <= 1'b0;
            rom_addr   <= '0;
            rom_din    <= '0;
            rom_we     <= 1'b0;
            cart_size  <= '0;
            cart_mask  <= '0;
            cart_valid <= 1'b0;
            cpu_hold   <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            dl_q       <= ioctl_download;
            pending    <= pending_n;
            pend_word  <= pend_word_n;
            pend_hi    <= pend_hi_n;
            stash      <= stash_n;
            stash_word <= stash_word_n;
            stash_odd  <= stash_odd_n;
            stash_data <= stash_data_n;
            end_seen   <= end_seen_n;
            ioctl_wait <= wait_n;
            rom_addr   <= rom_addr_n;
            rom_din    <= rom_din_n;
            rom_we     <= rom_we_n;
            cart_size  <= cart_size_n;
            cart_mask  <= cart_mask_n;
            cart_valid <= cart_valid_n;
            cpu_hold   <= cpu_hold_n;
            load_err   <= load_err_n;
        end
    end

endmodule
